// File: rtl/cpc_ga_pkg.sv
// Shared constants and types for the CPC gate-array timing blocks.
// Holds the line-counter geometry and the CPU wait-grid phase type.
package cpc_ga_pkg;

  localparam int CNT_W     = 6;
  localparam int INT_LINES = 52;
  localparam int VSYNC_DLY = 2;
  localparam int CNT_HALF  = 32;

  typedef logic [1:0] wait_phase_t;

endpackage

// File: rtl/cpc_int_counter.sv
// CPC 300 Hz raster interrupt source: counts HSYNC falls, resyncs after VSYNC,
// and clears the pending request on RMR writes or CPU interrupt acknowledge.
module cpc_int_counter
  import cpc_ga_pkg::*;
#(
  parameter int HSYNC_PER_INT = INT_LINES,
  parameter int VSYNC_DELAY   = VSYNC_DLY
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             hsync,
  input  logic             vsync,
  input  logic             m1_n,
  input  logic             iorq_n,
  input  logic             int_clr,
  output logic             int_pend,
  output logic [CNT_W-1:0] int_cnt
);

  localparam int               DLY_W = $clog2(VSYNC_DELAY + 1);
  localparam logic [CNT_W-1:0] WRAP  = CNT_W'(HSYNC_PER_INT - 1);
  localparam logic [CNT_W-1:0] HALF  = CNT_W'(CNT_HALF);

  logic             hsync_prev, vsync_prev, ack_prev;
  logic             ack_now, hsync_fall, vsync_rise, ack;
  logic [DLY_W-1:0] dly, dly_next;
  logic [CNT_W-1:0] cnt_acked, cnt_next;
  logic             pend_acked, pend_next;

  assign ack_now    = ~m1_n & ~iorq_n;
  assign hsync_fall = hsync_prev & ~hsync;
  assign vsync_rise = ~vsync_prev & vsync;
  assign ack        = ack_now & ~ack_prev;

  // Ack is applied first so the hsync update below sees the acknowledged count.
  assign cnt_acked  = ack ? {1'b0, int_cnt[CNT_W-2:0]} : int_cnt;
  assign pend_acked = int_pend & ~ack;

  // NOTE: every variable gets a default at the top of always_comb, so no path can infer a latch.
  always_comb begin
    cnt_next  = cnt_acked;
    pend_next = pend_acked;
    dly_next  = dly;
    if (int_clr) begin
      cnt_next  = '0;
      pend_next = 1'b0;
    end else if (hsync_fall) begin
      if (dly != '0) begin
        dly_next = dly - 1'b1;
        if (dly == DLY_W'(1)) begin
          cnt_next = '0;
          if (cnt_acked >= HALF) pend_next = 1'b1;
        end
      end else if (cnt_acked == WRAP) begin
        cnt_next  = '0;
        pend_next = 1'b1;
      end else begin
        cnt_next = cnt_acked + 1'b1;
      end
    end
    // A fresh VSYNC always restarts the resync delay, even mid-countdown.
    if (vsync_rise) dly_next = DLY_W'(VSYNC_DELAY);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hsync_prev <= 1'b0;
      vsync_prev <= 1'b0;
      ack_prev   <= 1'b0;
      dly        <= '0;
      int_cnt    <= '0;
      int_pend   <= 1'b0;
    end else begin
      hsync_prev <= hsync;
      vsync_prev <= vsync;
      ack_prev   <= ack_now;
      dly        <= dly_next;
      int_cnt    <= cnt_next;
      int_pend   <= pend_next;
    end
  end

endmodule

// File: rtl/cpc_int_wait_gen.sv
// Gate-array timing stage feeding the z80 wrapper: raster interrupt request
// plus a phase-locked wait_n that stretches bus accesses onto a 4-T-state grid.
module cpc_int_wait_gen
  import cpc_ga_pkg::*;
#(
  parameter int HSYNC_PER_INT = INT_LINES,
  parameter int VSYNC_DELAY   = VSYNC_DLY,
  parameter int WAIT_ENABLE   = 1,
  parameter int WAIT_PHASE    = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cpu_ce,
  input  logic             hsync,
  input  logic             vsync,
  input  logic             m1_n,
  input  logic             iorq_n,
  input  logic             int_clr,
  output logic             int_n,
  output logic             wait_n,
  output logic [CNT_W-1:0] int_cnt
);

  localparam wait_phase_t RELEASE  = wait_phase_t'(WAIT_PHASE);
  localparam logic        WAIT_OFF = (WAIT_ENABLE == 0);

  logic        int_pend;
  wait_phase_t phase, phase_next;

  cpc_int_counter #(
    .HSYNC_PER_INT (HSYNC_PER_INT),
    .VSYNC_DELAY   (VSYNC_DELAY)
  ) u_counter (
    .clk      (clk),
    .reset_n  (reset_n),
    .hsync    (hsync),
    .vsync    (vsync),
    .m1_n     (m1_n),
    .iorq_n   (iorq_n),
    .int_clr  (int_clr),
    .int_pend (int_pend),
    .int_cnt  (int_cnt)
  );

  assign int_n      = ~int_pend;
  assign phase_next = phase + 1'b1;

  // wait_n is released only in the grid slot that lands on RELEASE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase  <= '0;
      wait_n <= 1'b1;
    end else if (cpu_ce) begin
      phase  <= phase_next;
      wait_n <= (phase_next == RELEASE) | WAIT_OFF;
    end
  end

endmodule

// File: tb/tb_cpc_int_wait_gen.sv
// Self-checking bench for cpc_int_wait_gen: a spec-level model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_cpc_int_wait_gen;

  localparam int LINES = 52;
  localparam int WPH   = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cpu_ce = 1'b0, hsync = 1'b0, vsync = 1'b0;
  logic       m1_n = 1'b1, iorq_n = 1'b1, int_clr = 1'b0;
  logic       int_n, wait_n, int_n2, wait_n2;
  logic [5:0] int_cnt, int_cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  cpc_int_wait_gen dut (
    .clk(clk), .reset_n(reset_n), .cpu_ce(cpu_ce), .hsync(hsync), .vsync(vsync),
    .m1_n(m1_n), .iorq_n(iorq_n), .int_clr(int_clr),
    .int_n(int_n), .wait_n(wait_n), .int_cnt(int_cnt)
  );

  cpc_int_wait_gen #(.WAIT_ENABLE(0)) dut_nw (
    .clk(clk), .reset_n(reset_n), .cpu_ce(cpu_ce), .hsync(hsync), .vsync(vsync),
    .m1_n(m1_n), .iorq_n(iorq_n), .int_clr(int_clr),
    .int_n(int_n2), .wait_n(wait_n2), .int_cnt(int_cnt2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: line count, pending flag, resync countdown, cpu_ce pulses since reset.
  int m_cnt, m_dly, m_ce;
  bit m_pend, m_hp, m_vp, m_ap;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_cnt = 0; m_dly = 0; m_ce = 0;
      m_pend = 0; m_hp = 0; m_vp = 0; m_ap = 0;
    end else begin
      bit hfall, vrise, ackd;
      hfall = m_hp && !hsync;
      vrise = !m_vp && vsync;
      ackd  = (!m1_n && !iorq_n) && !m_ap;
      if (int_clr) begin
        m_cnt = 0;
        m_pend = 0;
      end else begin
        if (ackd) begin
          m_pend = 0;
          m_cnt  = m_cnt % 32;
        end
        if (hfall) begin
          if (m_dly > 0) begin
            m_dly--;
            if (m_dly == 0) begin
              if (m_cnt >= 32) m_pend = 1;
              m_cnt = 0;
            end
          end else begin
            m_cnt = (m_cnt + 1) % LINES;
            if (m_cnt == 0) m_pend = 1;
          end
        end
      end
      if (vrise) m_dly = 2;
      if (cpu_ce) m_ce++;
      m_hp = hsync;
      m_vp = vsync;
      m_ap = !m1_n && !iorq_n;
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      check("int_n", int_n, !m_pend);
      check("int_cnt", int_cnt, m_cnt);
      check("wait_n", wait_n, (m_ce == 0) ? 1 : ((m_ce % 4) == WPH));
      check("int_n_nw", int_n2, !m_pend);
      check("int_cnt_nw", int_cnt2, m_cnt);
      check("wait_n_nw", wait_n2, 1);
    end
  end

  // Free-running CPU T-state enable: one clk high every four.
  initial begin
    forever begin
      repeat (3) @(negedge clk);
      #1 cpu_ce = 1'b1;
      @(negedge clk);
      #1 cpu_ce = 1'b0;
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic hsync_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      hsync = 1'b1;
      wait_clks(2);
      hsync = 1'b0;
      wait_clks(2);
    end
  endtask

  task automatic vsync_pulse();
    vsync = 1'b1;
    wait_clks(2);
    vsync = 1'b0;
    wait_clks(1);
  endtask

  task automatic ack_cycle();
    m1_n = 1'b0; iorq_n = 1'b0;
    wait_clks(2);
    m1_n = 1'b1; iorq_n = 1'b1;
    wait_clks(1);
  endtask

  initial begin
    int highs;
    wait_clks(3);
    check("reset_int_n", int_n, 1);
    check("reset_int_cnt", int_cnt, 0);
    check("reset_wait_n", wait_n, 1);
    reset_n = 1'b1;
    wait_clks(2);

    // 104 lines, no acknowledge
    hsync_pulses(51);
    check("t1_cnt_51", int_cnt, 51);
    check("t1_int_n_51", int_n, 1);
    hsync_pulses(1);
    check("t1_cnt_52", int_cnt, 0);
    check("t1_int_n_52", int_n, 0);
    hsync_pulses(51);
    check("t1_cnt_103", int_cnt, 51);
    hsync_pulses(1);
    check("t1_cnt_104", int_cnt, 0);
    check("t1_int_n_104", int_n, 0);

    // Acknowledge at count 40
    hsync_pulses(40);
    check("t2_cnt_pre", int_cnt, 40);
    m1_n = 1'b0; iorq_n = 1'b0;
    wait_clks(1);
    check("t2_int_n_next", int_n, 1);
    check("t2_cnt_acked", int_cnt, 8);
    wait_clks(1);
    m1_n = 1'b1; iorq_n = 1'b1;
    wait_clks(1);

    // VSYNC resync from count 35 then 20
    hsync_pulses(27);
    check("t3_cnt_35", int_cnt, 35);
    vsync_pulse();
    hsync_pulses(1);
    check("t3_cnt_hold", int_cnt, 35);
    hsync_pulses(1);
    check("t3_cnt_resync", int_cnt, 0);
    check("t3_int_n_low", int_n, 0);
    ack_cycle();
    check("t3_int_n_acked", int_n, 1);
    hsync_pulses(20);
    check("t3_cnt_20", int_cnt, 20);
    vsync_pulse();
    hsync_pulses(2);
    check("t3_cnt_resync2", int_cnt, 0);
    check("t3_int_n_high", int_n, 1);

    // int_clr, ack and hsync fall together at count 51
    hsync_pulses(51);
    check("t4_cnt_51", int_cnt, 51);
    hsync = 1'b1;
    wait_clks(2);
    hsync = 1'b0; int_clr = 1'b1; m1_n = 1'b0; iorq_n = 1'b0;
    wait_clks(1);
    int_clr = 1'b0; m1_n = 1'b1; iorq_n = 1'b1;
    wait_clks(2);
    check("t4_cnt_clr", int_cnt, 0);
    check("t4_int_n_clr", int_n, 1);

    // Wait grid: 4 of every 16 clks high when enabled, never low when disabled
    highs = 0;
    repeat (32) begin
      @(negedge clk);
      highs += int'(wait_n);
    end
    #1;
    check("t5_wait_high_clks", highs, 8);

    // Asynchronous reset mid-count with interrupt pending
    hsync_pulses(52 + 30);
    check("t6_cnt_30", int_cnt, 30);
    check("t6_int_n_low", int_n, 0);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #2;
    check("t6_rst_int_n", int_n, 1);
    check("t6_rst_cnt", int_cnt, 0);
    check("t6_rst_wait_n", wait_n, 1);
    #10 reset_n = 1'b1;
    wait_clks(24);
    hsync_pulses(3);
    check("t6_cnt_after", int_cnt, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
